// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the external bus arbiter.
// Holds the FSM state enum, the master-count limit and a clog2 helper.
package ext_bus_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ext_bus_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// Ports: req, ptr in; one-hot gnt, binary idx, any out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/ext_bus_arb.sv
// N-master round-robin arbiter onto a single external bus.
// Ports: i_m_* per-master requests, o_m_* completions,
// o_ext_*/i_ext_* bus side. EXT_BUS_TIMEOUT_EN adds err timeout.
module ext_bus_arb
  import ext_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_MASTERS*AW-1:0]   i_m_addr,
  input  logic [N_MASTERS-1:0]      i_m_stb,
  input  logic [N_MASTERS*DW/8-1:0] i_m_we,
  input  logic [N_MASTERS*DW-1:0]   i_m_dat_w,
  output logic [N_MASTERS-1:0]      o_m_ack,
  output logic [N_MASTERS-1:0]      o_m_err,
  output logic [DW-1:0]             o_m_dat_r,
  output logic [AW-1:0]             o_ext_addr,
  output logic                      o_ext_stb,
  output logic [DW/8-1:0]           o_ext_we,
  input  logic                      i_ext_ack,
  output logic [DW-1:0]             o_ext_dat_w,
  input  logic [DW-1:0]             i_ext_dat_r
);

  localparam int N  = N_MASTERS;
  localparam int BW = DW / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t        state, nxt;
  logic [IW-1:0] ptr, g;
  logic [N-1:0]  g_oh;
  logic          live;
  logic          tmo;
  logic          done;
  logic [N-1:0]  a_gnt;
  logic [IW-1:0] a_idx;
  logic          a_any;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req (i_m_stb),
    .ptr (ptr),
    .gnt (a_gnt),
    .idx (a_idx),
    .any (a_any)
  );

`ifdef EXT_BUS_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q;

  // Held at zero outside BUSY, so entering BUSY starts from 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt <= '0;
    else if (state != BUSY)
      cnt <= '0;
    else if (!i_ext_ack)
      cnt <= cnt + CW'(1);
  end

  assign tmo = (state == BUSY) && !i_ext_ack &&
               (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      err_q <= 1'b0;
    else if (done)
      err_q <= !i_ext_ack;
  end
`else
  assign tmo = 1'b0;
`endif

  assign done = (state == BUSY) && (i_ext_ack || tmo);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (a_any) nxt = BUSY;
      BUSY:    if (done)  nxt = ACK;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // live drops if the granted master lets go of stb while BUSY,
  // which suppresses its ack pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr         <= '0;
      g           <= '0;
      g_oh        <= '0;
      live        <= 1'b0;
      o_ext_addr  <= '0;
      o_ext_we    <= '0;
      o_ext_dat_w <= '0;
      o_m_dat_r   <= '0;
    end else begin
      if (state == IDLE && a_any) begin
        g           <= a_idx;
        g_oh        <= a_gnt;
        live        <= 1'b1;
        o_ext_addr  <= i_m_addr[a_idx*AW +: AW];
        o_ext_we    <= i_m_we[a_idx*BW +: BW];
        o_ext_dat_w <= i_m_dat_w[a_idx*DW +: DW];
      end
      if (state == BUSY && !(|(i_m_stb & g_oh)))
        live <= 1'b0;
      if (done) begin
        ptr       <= (int'(g) == N - 1) ? '0 : g + IW'(1);
        o_m_dat_r <= i_ext_ack ? i_ext_dat_r : '0;
      end
    end
  end

  always_comb begin
    o_ext_stb = (state == BUSY);
    o_m_ack   = (state == ACK && live) ? g_oh : '0;
`ifdef EXT_BUS_TIMEOUT_EN
    o_m_err   = (state == ACK && live && err_q) ? g_oh : '0;
`else
    o_m_err   = '0;
`endif
  end

endmodule

// File: tb/tb_ext_bus_arb.sv
// Self-checking bench for ext_bus_arb, 4 masters, TIMEOUT=8.
// Reference model tracks rr pointer and per-master payloads.
module tb_ext_bus_arb;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]    m_stb;
  logic [N*BW-1:0] m_we;
  logic [N*DW-1:0] m_dat_w;
  logic [N-1:0]    m_ack, m_err;
  logic [DW-1:0]   m_dat_r;
  logic [AW-1:0]   ext_addr;
  logic            ext_stb;
  logic [BW-1:0]   ext_we;
  logic            ext_ack;
  logic [DW-1:0]   ext_dat_w;
  logic [DW-1:0]   ext_dat_r;

  int vecs = 0;
  int miss = 0;
  int ptr  = 0;
  logic [AW-1:0] a_m [N];
  logic [BW-1:0] w_m [N];
  logic [DW-1:0] d_m [N];

  ext_bus_arb #(
    .N_MASTERS (N),
    .AW        (AW),
    .DW        (DW),
    .TIMEOUT   (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_m_addr    (m_addr),
    .i_m_stb     (m_stb),
    .i_m_we      (m_we),
    .i_m_dat_w   (m_dat_w),
    .o_m_ack     (m_ack),
    .o_m_err     (m_err),
    .o_m_dat_r   (m_dat_r),
    .o_ext_addr  (ext_addr),
    .o_ext_stb   (ext_stb),
    .o_ext_we    (ext_we),
    .i_ext_ack   (ext_ack),
    .o_ext_dat_w (ext_dat_w),
    .i_ext_dat_r (ext_dat_r)
  );

  always #5 clk = ~clk;

  function automatic int pick();
    for (int i = 0; i < N; i++)
      if (m_stb[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [AW-1:0] a,
                         input logic [BW-1:0] w,
                         input logic [DW-1:0] d);
    a_m[k] = a;
    w_m[k] = w;
    d_m[k] = d;
    m_addr[k*AW +: AW]  = a;
    m_we[k*BW +: BW]    = w;
    m_dat_w[k*DW +: DW] = d;
    m_stb[k] = 1'b1;
  endtask

  task automatic rand_req(input int k);
    set_req(k, AW'($urandom), BW'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    m_stb     = '0;
    m_addr    = '0;
    m_we      = '0;
    m_dat_w   = '0;
    ext_ack   = 1'b0;
    ext_dat_r = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ptr   = 0;
    @(negedge clk);
  endtask

  // Starts at a negedge in the IDLE cycle where the request is
  // visible; ends at the negedge of the ACK cycle.
  task automatic serve(input int d, input logic [DW-1:0] rd,
                       input int drop_at, output int g);
    logic [N-1:0] want;
    g = pick();
    @(negedge clk);
    for (int i = 0; i <= d; i++) begin
      vecs++;
      if (ext_stb !== 1'b1 || ext_addr !== a_m[g] ||
          ext_we !== w_m[g] || ext_dat_w !== d_m[g] ||
          m_ack !== '0) begin
        miss++;
        $display("FAIL busy g=%0d cyc=%0d: stb=%b addr=%h we=%h dat=%h ack=%b want 1 %h %h %h 0",
                 g, i, ext_stb, ext_addr, ext_we, ext_dat_w, m_ack,
                 a_m[g], w_m[g], d_m[g]);
      end
      if (i == drop_at) m_stb[g] = 1'b0;
      ext_ack   = (i == d);
      ext_dat_r = (i == d) ? rd : $urandom;
      @(negedge clk);
    end
    ext_ack = 1'b0;
    want = (drop_at >= 0) ? '0 : N'(1 << g);
    vecs++;
    if (ext_stb !== 1'b0 || m_ack !== want || m_err !== '0 ||
        m_dat_r !== rd) begin
      miss++;
      $display("FAIL ack g=%0d: stb=%b ack=%b err=%b dat_r=%h want 0 %b 0 %h",
               g, ext_stb, m_ack, m_err, m_dat_r, want, rd);
    end
    m_stb[g] = 1'b0;
    ptr = (g + 1) % N;
  endtask

  task automatic to_idle();
    @(negedge clk);
    vecs++;
    if (ext_stb !== 1'b0 || m_ack !== '0) begin
      miss++;
      $display("FAIL idle: stb=%b ack=%b want 0 0", ext_stb, m_ack);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_stb = '0;
    ext_ack = 1'b0;
    ext_dat_r = '0;
    @(negedge clk);
    vecs++;
    if (ext_stb !== 0 || m_ack !== 0 || m_err !== 0 ||
        m_dat_r !== 0 || ext_addr !== 0 || ext_we !== 0 ||
        ext_dat_w !== 0) begin
      miss++;
      $display("FAIL reset: stb=%b ack=%b err=%b dr=%h a=%h we=%h dw=%h want all 0",
               ext_stb, m_ack, m_err, m_dat_r, ext_addr, ext_we, ext_dat_w);
    end
    apply_reset();
    to_idle();
  endtask

  task automatic test_single_write();
    int g;
    apply_reset();
    set_req(0, 16'h0010, 4'hF, 32'hCAFEBABE);
    serve(2, 32'h5A5A0001, -1, g);
    to_idle();
  endtask

  task automatic test_simultaneous();
    int g;
    apply_reset();
    set_req(0, 16'h0100, 4'h0, 32'h0);
    set_req(1, 16'h0200, 4'h0, 32'h0);
    serve(0, 32'h11111111, -1, g);
    to_idle();
    serve(1, 32'h22222222, -1, g);
    to_idle();
  endtask

  task automatic test_pointer();
    int g;
    apply_reset();
    set_req(1, 16'h1111, 4'h3, 32'hA1);
    serve(0, 32'h0000_00B1, -1, g);
    to_idle();
    set_req(0, 16'h2000, 4'h1, 32'hC0);
    set_req(1, 16'h2001, 4'h2, 32'hC1);
    set_req(3, 16'h2003, 4'h8, 32'hC3);
    for (int k = 0; k < 3; k++) begin
      serve(k, 32'hD000_0000 + k, -1, g);
      to_idle();
    end
  endtask

  task automatic test_fairness();
    int g;
    apply_reset();
    rand_req(3);
    for (int t = 0; t < 30; t++) begin
      serve($urandom_range(0, 3), $urandom, -1, g);
      if (g == 3) rand_req(3);
      for (int k = 0; k < 2; k++)
        if (!m_stb[k] && $urandom_range(0, 2) == 0) rand_req(k);
      to_idle();
    end
    m_stb = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int g;
    apply_reset();
    for (int k = 0; k < N; k++) rand_req(k);
    for (int k = 0; k < N; k++) begin
      serve(0, $urandom, -1, g);
      to_idle();
    end
  endtask

  task automatic test_drop();
    int g;
    apply_reset();
    set_req(2, 16'h0BAD, 4'h0, 32'h0);
    serve(3, 32'h77778888, 1, g);
    to_idle();
    set_req(2, 16'h0C02, 4'h0, 32'h0);
    set_req(3, 16'h0C03, 4'h0, 32'h0);
    serve(0, 32'h99990003, -1, g);
    to_idle();
    m_stb = '0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int g;
    int bad;
    apply_reset();
    set_req(2, 16'h00A2, 4'h0, 32'h0);
    serve(0, 32'hFEEDF00D, -1, g);
    to_idle();
    set_req(3, 16'h00A3, 4'hF, 32'h12345678);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (ext_stb !== 0 || m_ack !== 0 || m_err !== 0 ||
        m_dat_r !== 0 || ext_addr !== 0 || ext_we !== 0 ||
        ext_dat_w !== 0) begin
      miss++;
      $display("FAIL async_rst: stb=%b ack=%b err=%b dr=%h a=%h we=%h dw=%h want all 0",
               ext_stb, m_ack, m_err, m_dat_r, ext_addr, ext_we, ext_dat_w);
    end
    m_stb   = '0;
    ext_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ptr   = 0;
    bad   = 0;
    repeat (4) begin
      @(negedge clk);
      if (ext_stb !== 0 || m_ack !== 0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      miss++;
      $display("FAIL post_rst_quiet: bad_cycles=%0d want 0", bad);
    end
    ext_ack = 1'b0;
    set_req(1, 16'h00B1, 4'h0, 32'h0);
    serve(1, 32'h0BADCAFE, -1, g);
    to_idle();
  endtask

`ifdef EXT_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int g;
    apply_reset();
    set_req(0, 16'h0E00, 4'h0, 32'h0);
    serve(7, 32'hABCD0007, -1, g);
    to_idle();
    set_req(1, 16'h0E01, 4'hF, 32'h5555AAAA);
    set_req(2, 16'h0E02, 4'h0, 32'h0);
    g = pick();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (ext_stb !== 1'b1 || m_ack !== '0) begin
        miss++;
        $display("FAIL tmo_busy cyc=%0d: stb=%b ack=%b want 1 0",
                 i, ext_stb, m_ack);
      end
      @(negedge clk);
    end
    vecs++;
    if (ext_stb !== 0 || m_ack !== N'(1 << g) ||
        m_err !== N'(1 << g) || m_dat_r !== '0) begin
      miss++;
      $display("FAIL tmo_ack: stb=%b ack=%b err=%b dr=%h want 0 %b %b 0",
               ext_stb, m_ack, m_err, m_dat_r, N'(1 << g), N'(1 << g));
    end
    m_stb[g] = 1'b0;
    ptr = (g + 1) % N;
    to_idle();
    serve(0, 32'h2222BEEF, -1, g);
    to_idle();
  endtask
`else
  task automatic test_timeout();
    int stuck;
    apply_reset();
    set_req(0, 16'h0E00, 4'h0, 32'h0);
    @(negedge clk);
    stuck = 0;
    repeat (1000) begin
      if (ext_stb !== 1'b1 || m_ack !== '0 || m_err !== '0)
        stuck++;
      @(negedge clk);
    end
    vecs++;
    if (stuck != 0) begin
      miss++;
      $display("FAIL no_tmo_hold: bad_cycles=%0d want 0", stuck);
    end
    apply_reset();
  endtask
`endif

  task automatic test_stray_ack();
    int bad;
    int g;
    apply_reset();
    bad = 0;
    ext_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ext_stb !== 0 || m_ack !== 0) bad++;
    end
    ext_ack = 1'b0;
    vecs++;
    if (bad != 0) begin
      miss++;
      $display("FAIL stray_ack: bad_cycles=%0d want 0", bad);
    end
    set_req(3, 16'h0F03, 4'h0, 32'h0);
    serve(1, 32'h3C3C3C3C, -1, g);
    ext_ack = 1'b1;
    to_idle();
    ext_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_pointer();
    test_back_to_back();
    test_fairness();
    test_drop();
    test_stray_ack();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
